// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/result path.
//   MAX_CH   : largest supported channel count for shared muxes
//   sel_t    : channel index wide enough for MAX_CH channels
//   next_idx : modulo-n increment of a channel index
package alu_pkg;

  localparam int MAX_CH   = 16;
  localparam int MAX_SELW = $clog2(MAX_CH);

  typedef logic [MAX_SELW-1:0] sel_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_mux_reg_pick.sv
// Rotating-priority encoder: returns the first set bit of valid, scanning
// upward from ptr and wrapping modulo N.
//   valid : per-channel request
//   ptr   : index with highest priority (must be < N)
//   found : at least one request is set
//   idx   : index of the winning request (0 when found=0)
module rr_pick #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  // Scan from the lowest priority to the highest so the last hit wins.
  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (valid[c[SELW-1:0]]) begin
        found = 1'b1;
        idx   = c[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-input WIDTH-bit mux with a registered output and valid/ready on every
// channel. Selection is round-robin among valid inputs or a forced index.
//   clk, rst            : clock, async active-high reset
//   in_data/in_valid    : channel i data at [i*WIDTH +: WIDTH], request
//   in_ready            : channel i accepted this cycle (one-hot or zero)
//   force_en/force_sel  : forced-select mode and its channel index
//   out_data/out_sel    : registered data and the channel that supplied it
//   out_valid/out_ready : output handshake
module rr_mux_reg
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  if (N < 2 || N > MAX_CH) begin : g_bad_n
    $error("rr_mux_reg: N must be in 2..%0d", MAX_CH);
  end

  logic             can_load;
  logic             pick_found;
  logic [SELW-1:0]  pick_idx;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [SELW-1:0]  rr_ptr;

  rr_pick #(.N(N)) u_pick (
    .valid (in_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Empty, or being drained this cycle: one transfer per cycle sustained.
  assign can_load = !out_valid || out_ready;

  // Forced mode matches force_sel against each legal index, so an
  // out-of-range select simply never matches and never grants.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (force_en) begin
      for (int i = 0; i < N; i++) begin
        if (force_sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      grant_vld = pick_found;
      grant_idx = pick_idx;
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !rst && can_load && grant_vld;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (can_load && grant_vld) begin
      out_data  <= grant_data;
      out_sel   <= grant_idx;
      out_valid <= 1'b1;
      if (!force_en) rr_ptr <= SELW'(next_idx(int'(grant_idx), N));
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: an N=4 instance checked every cycle
// against a behavioural model plus literal expectations, and an N=3
// instance for the out-of-range forced select.
module tb_rr_mux_reg;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  // N=4 instance
  logic [4*W-1:0] in_data4;
  logic [3:0]     in_valid4, in_ready4;
  logic           force_en4, out_valid4, out_ready4;
  logic [1:0]     force_sel4, out_sel4;
  logic [W-1:0]   out_data4;

  // N=3 instance
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic           force_en3, out_valid3, out_ready3;
  logic [1:0]     force_sel3, out_sel3;
  logic [W-1:0]   out_data3;

  int vec_cnt = 0;
  int err_cnt = 0;

  rr_mux_reg #(.WIDTH(W), .N(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .force_en(force_en4), .force_sel(force_sel4),
    .out_data(out_data4), .out_sel(out_sel4), .out_valid(out_valid4),
    .out_ready(out_ready4)
  );

  rr_mux_reg #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .force_en(force_en3), .force_sel(force_sel3),
    .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the N=4 instance: the output register is a
  // single held transfer; the pointer says who has priority next.
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_sel;
  int         m_ptr;

  always @(negedge clk) begin
    bit         g_found;
    int         g;
    bit         can;
    logic [3:0] er;
    if (rst) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
    end
    g_found = 0; g = 0;
    if (!rst) begin
      if (force_en4) begin
        if (int'(force_sel4) < 4 && in_valid4[force_sel4]) begin
          g_found = 1; g = int'(force_sel4);
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!g_found && in_valid4[(m_ptr + k) % 4]) begin
            g_found = 1; g = (m_ptr + k) % 4;
          end
        end
      end
    end
    can = !m_valid || out_ready4;
    er  = '0;
    if (can && g_found) er[g] = 1'b1;

    chk("model out_valid", out_valid4, m_valid);
    chk("model out_data",  out_data4,  m_data);
    chk("model out_sel",   out_sel4,   m_sel);
    chk("model in_ready",  in_ready4,  er);

    if (!rst) begin
      if (can && g_found) begin
        m_valid = 1;
        m_data  = in_data4[g*W +: W];
        m_sel   = g;
        if (!force_en4) m_ptr = (g + 1) % 4;
      end else if (m_valid && out_ready4) begin
        m_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    for (int i = 0; i < 4; i++) in_data4[i*W +: W] = 32'hA0 + i;
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = 32'hC0 + i;
    in_valid4  = '0; force_en4 = 0; force_sel4 = '0; out_ready4 = 1;
    in_valid3  = 3'b111; force_en3 = 1; force_sel3 = 2'd3; out_ready3 = 1;
    step();
    step();

    // Round-robin fairness: 0,1,2,3,0 then 1,2.
    chk("reset out_valid", out_valid4, 1'b0);
    rst = 1'b0;
    in_valid4 = 4'b1111;
    for (int n = 0; n < 7; n++) begin
      step();
      chk("rr out_sel",  out_sel4,  n % 4);
      chk("rr out_data", out_data4, 32'hA0 + (n % 4));
      chk("rr out_valid", out_valid4, 1'b1);
    end

    // Skip and wrap: pointer at 3, only channels 0 and 2 requesting.
    in_valid4 = 4'b0101;
    step();
    chk("wrap sel0", out_sel4, 2'd0);
    step();
    chk("wrap sel2", out_sel4, 2'd2);
    chk("wrap data", out_data4, 32'hA2);

    // Backpressure: load DEADBEEF from channel 0, then stall 3 cycles.
    in_data4[0 +: W] = 32'hDEADBEEF;
    in_valid4 = 4'b0001;
    step();
    chk("bp load data", out_data4, 32'hDEADBEEF);
    out_ready4 = 0;
    in_valid4  = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("bp stall data",  out_data4,  32'hDEADBEEF);
      chk("bp stall valid", out_valid4, 1'b1);
      chk("bp stall ready", in_ready4,  4'b0000);
    end
    out_ready4 = 1;
    in_valid4  = 4'b0000;
    step();
    chk("bp drain valid", out_valid4, 1'b0);
    chk("bp drain data",  out_data4,  32'hDEADBEEF);

    // Forced mode; pointer is at 1 and must stay there.
    force_en4 = 1; force_sel4 = 2'd2; in_valid4 = 4'b0111;
    #1;
    chk("force in_ready", in_ready4, 4'b0100);
    step();
    chk("force out_sel",  out_sel4,  2'd2);
    chk("force out_data", out_data4, 32'hA2);
    in_valid4 = 4'b1011;
    #1;
    chk("force idle ready", in_ready4, 4'b0000);
    step();
    chk("force idle valid", out_valid4, 1'b0);
    force_en4 = 0; in_valid4 = 4'b1111;
    step();
    chk("ptr kept sel", out_sel4, 2'd1);

    // Reset mid-stall clears immediately.
    out_ready4 = 0;
    step();
    step();
    chk("stall before rst", out_valid4, 1'b1);
    rst = 1'b1;
    #1;
    chk("async rst valid", out_valid4, 1'b0);
    chk("async rst data",  out_data4,  32'h0);
    chk("async rst sel",   out_sel4,   2'd0);
    chk("rst in_ready",    in_ready4,  4'b0000);
    step();
    rst = 1'b0; in_valid4 = 4'b0110; out_ready4 = 1;
    step();
    chk("post rst sel",  out_sel4,  2'd1);
    chk("post rst data", out_data4, 32'hA1);

    // N=3, forced select 3 is out of range: nothing ever transfers.
    for (int n = 0; n < 5; n++) begin
      step();
      chk("illegal in_ready",  in_ready3,  3'b000);
      chk("illegal out_valid", out_valid3, 1'b0);
    end
    force_sel3 = 2'd2;
    #1;
    chk("n3 force ready", in_ready3, 3'b100);
    step();
    chk("n3 force sel",  out_sel3,  2'd2);
    chk("n3 force data", out_data3, 32'hC2);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
